// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between an instruction-fetch port and a load/store port.
// Optional fetch-starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StFetch, StData, StResp} state_e;

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  if (TIMEOUT < 1 || TIMEOUT > 255 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_params
    $error("mem_arbiter: TIMEOUT must be 1..255 and MAX_BURST 1..15");
  end

  state_e            state_q, state_d;
  logic              grant_fetch, grant_data, mem_done, mem_timeout;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, d_rdata_q;
  logic              we_q, owner_q, err_q;
  logic [7:0]        wait_q;
  logic              force_fetch;

`ifdef ARB_STARVE_GUARD_EN
  // Counts data grants taken while fetch was waiting; a full count hands the next slot to fetch.
  logic [3:0] burst_q;

  assign force_fetch = if_req && (burst_q >= 4'(MAX_BURST));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      burst_q <= '0;
    end else if (grant_fetch) begin
      burst_q <= '0;
    end else if (grant_data && if_req && (burst_q != 4'hf)) begin
      burst_q <= burst_q + 4'd1;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    mem_done    = 1'b0;
    mem_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (force_fetch) begin
          grant_fetch = 1'b1;
          state_d     = StFetch;
        end else if (d_req) begin
          grant_data = 1'b1;
          state_d    = StData;
        end else if (if_req) begin
          grant_fetch = 1'b1;
          state_d     = StFetch;
        end
      end
      StFetch, StData: begin
        if (mem_ready) begin
          mem_done = 1'b1;
          state_d  = StResp;
        end else if (wait_q == WaitLast) begin
          mem_timeout = 1'b1;
          state_d     = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request fields are captured at grant so requesters may change them freely afterwards.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_q    <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (grant_fetch || grant_data) begin
      addr_q  <= grant_data ? d_addr : if_addr;
      wdata_q <= grant_data ? d_wdata : '0;
      we_q    <= grant_data && d_we;
      owner_q <= grant_data;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else if (mem_done) begin
      if (!owner_q) begin
        if_rdata_q <= mem_rdata;
      end else if (!we_q) begin
        d_rdata_q <= mem_rdata;
      end
    end else if (mem_timeout) begin
      err_q <= 1'b1;
      if (!owner_q) begin
        if_rdata_q <= '0;
      end else begin
        d_rdata_q <= '0;
      end
    end else if ((state_q == StFetch) || (state_q == StData)) begin
      wait_q <= wait_q + 8'd1;
    end
  end

  always_comb begin
    mem_req = (state_q == StFetch) || (state_q == StData);
    mem_we  = (state_q == StData) && we_q;
    if_ack  = (state_q == StResp) && !owner_q;
    d_ack   = (state_q == StResp) && owner_q;
    err     = (state_q == StResp) && err_q;
    busy    = (state_q != StIdle);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
